// File: rtl/id_pkg.sv
// Shared decode definitions for the MIPS decode stage.
// Opcode constants, the decoded-field bundle and field extraction helpers.
// No state lives here; everything is pure combinational helpers and types.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction-derived fields carried in the output register. The
    // XLEN-wide operand/address fields sit beside this bundle in the stage
    // because their width is a stage parameter.
    typedef struct packed {
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       mem_read;
    } dec_fields_t;

    function automatic dec_fields_t decode_fields(input logic [31:0] instr);
        dec_fields_t f;
        f.opcode   = instr[31:26];
        f.funct    = instr[5:0];
        f.rs       = instr[25:21];
        f.rt       = instr[20:16];
        f.rd       = instr[15:11];
        f.mem_read = (instr[31:26] == OP_LW);
        return f;
    endfunction

    // True when a pending load into ld_rt feeds either source of instr.
    function automatic logic load_use(input logic [4:0]  ld_rt,
                                      input logic [31:0] instr);
        return (ld_rt != 5'd0) &&
               ((ld_rt == instr[25:21]) || (ld_rt == instr[20:16]));
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 2 combinational read ports, 1 write port.
// Reads are same-cycle; a write lands on the rising edge.
// No flow control; a same-cycle write to a read address is bypassed to the read.
module reg_file #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [RAW-1:0]  wa,
    input  logic [XLEN-1:0] wd
);

    // Register 0 has no storage: it is hardwired to zero on every path.
    logic [XLEN-1:0] regs [1:NREGS-1];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    // Storage update; reset clears every architectural register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Read port 1 with write-to-read bypass.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = (wr_en && (wa == ra1)) ? wd : regs[ra1];
        end
    end

    // Read port 2 with write-to-read bypass.
    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = (wr_en && (wa == ra2)) ? wd : regs[ra2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: field extraction, register read, branch/jump targets, one output register.
// Latency 1 cycle from accept to ex_valid; 1 instruction/cycle without hazards.
// Stalls fetch when execute backpressures or on a load-use hazard (one bubble).
module id_stage
    import id_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [5:0]      ex_opcode,
    output logic [5:0]      ex_funct,
    output logic [4:0]      ex_rs,
    output logic [4:0]      ex_rt,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rs_data,
    output logic [XLEN-1:0] ex_rt_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_branch_dest,
    output logic [XLEN-1:0] ex_jump_dest,
    output logic            ex_mem_read
);

    // Output register occupancy.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state;
    logic [0:0]      state_nxt;

    // Combinational decode of the incoming instruction.
    dec_fields_t     dec;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] branch_dest;
    logic [XLEN-1:0] jump_dest;

    // Output pipeline register contents.
    dec_fields_t     q_fields;
    logic [XLEN-1:0] q_rs_data;
    logic [XLEN-1:0] q_rt_data;
    logic [XLEN-1:0] q_imm;
    logic [XLEN-1:0] q_branch_dest;
    logic [XLEN-1:0] q_jump_dest;

    logic            load;
    logic            hazard;

    assign dec = decode_fields(if_instr);

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (dec.rs[RAW-1:0]),
        .ra2   (dec.rt[RAW-1:0]),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (wb_we),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // Immediate and control-flow targets; additions wrap at XLEN bits.
    always_comb begin
        pc4         = if_pc + XLEN'(4);
        imm         = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
        branch_dest = pc4 + (imm << 2);
        jump_dest   = {pc4[XLEN-1:28], if_instr[25:0], 2'b00};
    end

    // The register can take new data when it is empty or being drained;
    // a load in flight whose target feeds the incoming instruction must
    // leave the stage before its consumer is decoded.
    always_comb begin
        load     = ex_ready || !ex_valid;
        hazard   = ex_valid && q_fields.mem_read && if_valid &&
                   load_use(q_fields.rt, if_instr);
        id_ready = load && !hazard;
    end

    // Occupancy transitions: flush and bubbles empty the register, an
    // accept fills it, and a stall holds it.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else if (load && hazard) begin
            state_nxt = ST_EMPTY;
        end else if (load) begin
            state_nxt = if_valid ? ST_FULL : ST_EMPTY;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload capture; bubbles and flushes leave the payload untouched
    // since only ex_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_fields      <= '0;
            q_rs_data     <= '0;
            q_rt_data     <= '0;
            q_imm         <= '0;
            q_branch_dest <= '0;
            q_jump_dest   <= '0;
        end else if (!flush && load && !hazard) begin
            q_fields      <= dec;
            q_rs_data     <= rs_val;
            q_rt_data     <= rt_val;
            q_imm         <= imm;
            q_branch_dest <= branch_dest;
            q_jump_dest   <= jump_dest;
        end
    end

    assign ex_valid       = (state == ST_FULL);
    assign ex_opcode      = q_fields.opcode;
    assign ex_funct       = q_fields.funct;
    assign ex_rs          = q_fields.rs;
    assign ex_rt          = q_fields.rt;
    assign ex_rd          = q_fields.rd;
    assign ex_mem_read    = q_fields.mem_read;
    assign ex_rs_data     = q_rs_data;
    assign ex_rt_data     = q_rt_data;
    assign ex_imm         = q_imm;
    assign ex_branch_dest = q_branch_dest;
    assign ex_jump_dest   = q_jump_dest;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage against an architectural reference model.
module tb_id_stage;
    import id_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        id_ready;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_ready = 1'b0;
    logic        ex_valid;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_branch_dest, ex_jump_dest;
    logic        ex_mem_read;

    always #5 clk = ~clk;

    id_stage #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_branch_dest(ex_branch_dest), .ex_jump_dest(ex_jump_dest),
        .ex_mem_read(ex_mem_read)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] br;
        logic [31:0] jd;
        logic        mr;
    } bundle_t;

    logic [31:0] mregs [32];
    int n_pass  = 0;
    int n_total = 0;

    // Architectural read as seen during the current cycle.
    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    // Expected decode of one instruction, from the ISA definitions.
    function automatic bundle_t model_bundle(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t b;
        int s;
        s    = $signed(instr[15:0]);
        b.op = instr[31:26];
        b.fn = instr[5:0];
        b.rs = instr[25:21];
        b.rt = instr[20:16];
        b.rd = instr[15:11];
        b.a  = rd_model(instr[25:21]);
        b.b  = rd_model(instr[20:16]);
        b.imm = s;
        b.br = pc + 32'd4 + 32'(s * 4);
        b.jd = ((pc + 32'd4) & 32'hF000_0000) | (32'(instr[25:0]) << 2);
        b.mr = (instr[31:26] == 6'h23);
        return b;
    endfunction

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b = {ex_opcode, ex_funct, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data,
             ex_imm, ex_branch_dest, ex_jump_dest, ex_mem_read};
        return b;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    // One clock edge; the model's register file follows write-back.
    task automatic cycle();
        @(posedge clk);
        if (wb_we && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ex_ready = 1; if_valid = 1; if_instr = 32'h012A4020; if_pc = 32'h100;
        wb_we = 1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
        cycle();
        @(negedge clk);
        wb_addr = 5'd10; wb_data = 32'h0000_00AA;
        cycle();
        @(negedge clk);
        wb_we = 0;
        #2 rst_n = 0;
        if_valid = 0; if_instr = '0; if_pc = '0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        #1;
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid);
        else n_pass++;
        n_total++;
        if (dut_bundle() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_bundle());
        else n_pass++;
        n_total++;
        if (id_ready !== 1'b1) $display("FAIL reset_id_ready: got %b want 1", id_ready);
        else n_pass++;
        @(negedge clk);
        if_valid = 1; if_instr = 32'h012A4020; if_pc = 32'h200;
        cycle();
        n_total++;
        if (ex_valid !== 1'b1) $display("FAIL reset_decode_valid: got %b want 1", ex_valid);
        else n_pass++;
        n_total++;
        if (ex_rs_data !== 32'd0) $display("FAIL reset_rs_data: got %h want 0", ex_rs_data);
        else n_pass++;
        n_total++;
        if (ex_rt_data !== 32'd0) $display("FAIL reset_rt_data: got %h want 0", ex_rt_data);
        else n_pass++;
    endtask

    task automatic test_bypass();
        bundle_t e;
        @(negedge clk);
        ex_ready = 1; if_valid = 1; if_instr = rtype(5'd5, 5'd6, 5'd7, 6'h20); if_pc = 32'h300;
        wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        e = model_bundle(if_instr, if_pc);
        cycle();
        n_total++;
        if (ex_rs_data !== 32'hDEADBEEF) $display("FAIL bypass_rs: got %h want deadbeef", ex_rs_data);
        else n_pass++;
        n_total++;
        if (dut_bundle() !== e) $display("FAIL bypass_bundle: got %h want %h", dut_bundle(), e);
        else n_pass++;
        @(negedge clk);
        if_instr = rtype(5'd0, 5'd0, 5'd3, 6'h20); if_pc = 32'h304;
        wb_addr = 5'd0; wb_data = 32'h0000_1234;
        cycle();
        n_total++;
        if ({ex_rs_data, ex_rt_data} !== 64'd0)
            $display("FAIL r0_write_read: got %h %h want 0 0", ex_rs_data, ex_rt_data);
        else n_pass++;
        @(negedge clk);
        wb_we = 0; if_instr = rtype(5'd0, 5'd5, 5'd3, 6'h20); if_pc = 32'h308;
        cycle();
        n_total++;
        if ({ex_rs_data, ex_rt_data} !== {32'd0, 32'hDEADBEEF})
            $display("FAIL r0_after_write: got %h %h want 0 deadbeef", ex_rs_data, ex_rt_data);
        else n_pass++;
    endtask

    task automatic test_addr();
        @(negedge clk);
        ex_ready = 1; if_valid = 1; wb_we = 0;
        if_instr = {OP_BEQ, 5'd1, 5'd2, 16'hFFFF}; if_pc = 32'h0040_0000;
        cycle();
        n_total++;
        if (ex_branch_dest !== 32'h0040_0000) $display("FAIL branch_dest: got %h want 00400000", ex_branch_dest);
        else n_pass++;
        n_total++;
        if (ex_imm !== 32'hFFFF_FFFF) $display("FAIL imm_sext: got %h want ffffffff", ex_imm);
        else n_pass++;
        @(negedge clk);
        if_instr = 32'h0800_0010; if_pc = 32'h1000_0004;
        cycle();
        n_total++;
        if (ex_jump_dest !== 32'h1000_0040) $display("FAIL jump_dest: got %h want 10000040", ex_jump_dest);
        else n_pass++;
        n_total++;
        if (ex_opcode !== OP_J) $display("FAIL jump_opcode: got %h want 02", ex_opcode);
        else n_pass++;
    endtask

    task automatic test_load_use();
        bundle_t e;
        @(negedge clk);
        ex_ready = 1; if_valid = 1; wb_we = 0;
        if_instr = {OP_LW, 5'd0, 5'd8, 16'h0010}; if_pc = 32'h500;
        #1;
        n_total++;
        if (id_ready !== 1'b1) $display("FAIL lw_accept_ready: got %b want 1", id_ready);
        else n_pass++;
        cycle();
        n_total++;
        if ({ex_valid, ex_mem_read, ex_rt} !== {1'b1, 1'b1, 5'd8})
            $display("FAIL lw_issued: got %b%b %0d want 1 1 8", ex_valid, ex_mem_read, ex_rt);
        else n_pass++;
        @(negedge clk);
        if_instr = rtype(5'd8, 5'd1, 5'd9, 6'h20); if_pc = 32'h504;
        #1;
        n_total++;
        if (id_ready !== 1'b0) $display("FAIL hazard_stall: got id_ready %b want 0", id_ready);
        else n_pass++;
        cycle();
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL hazard_bubble: got ex_valid %b want 0", ex_valid);
        else n_pass++;
        @(negedge clk);
        wb_we = 1; wb_addr = 5'd8; wb_data = 32'hCAFE_0008;
        #1;
        n_total++;
        if (id_ready !== 1'b1) $display("FAIL hazard_release: got id_ready %b want 1", id_ready);
        else n_pass++;
        e = model_bundle(if_instr, if_pc);
        cycle();
        n_total++;
        if (ex_valid !== 1'b1 || ex_rs_data !== 32'hCAFE_0008)
            $display("FAIL add_issue: got valid %b rs %h want 1 cafe0008", ex_valid, ex_rs_data);
        else n_pass++;
        n_total++;
        if (dut_bundle() !== e) $display("FAIL add_bundle: got %h want %h", dut_bundle(), e);
        else n_pass++;
        wb_we = 0;
    endtask

    task automatic test_backpressure_flush();
        bundle_t ea, ec;
        @(negedge clk);
        ex_ready = 1; if_valid = 1; wb_we = 0;
        if_instr = rtype(5'd3, 5'd4, 5'd5, 6'h20); if_pc = 32'h3000;
        ea = model_bundle(if_instr, if_pc);
        cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_ready = 0; if_instr = rtype(5'd6, 5'd7, 5'd2, 6'h22); if_pc = 32'h3004;
            wb_we = 1; wb_addr = 5'd3; wb_data = $urandom;
            #1;
            n_total++;
            if (id_ready !== 1'b0) $display("FAIL stall_ready[%0d]: got %b want 0", i, id_ready);
            else n_pass++;
            cycle();
            n_total++;
            if (ex_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, ex_valid);
            else n_pass++;
            n_total++;
            if (dut_bundle() !== ea) $display("FAIL stall_stable[%0d]: got %h want %h", i, dut_bundle(), ea);
            else n_pass++;
        end
        @(negedge clk);
        wb_we = 0; flush = 1;
        cycle();
        n_total++;
        if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ex_valid);
        else n_pass++;
        @(negedge clk);
        flush = 0; ex_ready = 1;
        if_instr = rtype(5'd1, 5'd2, 5'd3, 6'h25); if_pc = 32'h3008;
        #1;
        n_total++;
        if (id_ready !== 1'b1) $display("FAIL post_flush_ready: got %b want 1", id_ready);
        else n_pass++;
        ec = model_bundle(if_instr, if_pc);
        cycle();
        n_total++;
        if (ex_valid !== 1'b1 || dut_bundle() !== ec)
            $display("FAIL post_flush_next: got %b %h want 1 %h", ex_valid, dut_bundle(), ec);
        else n_pass++;
    endtask

    task automatic test_throughput();
        logic [5:0] ops [4];
        bundle_t e;
        ops[0] = OP_RTYPE; ops[1] = OP_BEQ; ops[2] = OP_SW; ops[3] = OP_J;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ex_ready = 1; if_valid = 1; flush = 0;
            if_instr = {ops[$urandom_range(0, 3)], 26'($urandom)};
            if_pc = 32'h4000 + 32'(i * 4);
            wb_we = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
            #1;
            n_total++;
            if (id_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, id_ready);
            else n_pass++;
            e = model_bundle(if_instr, if_pc);
            cycle();
            n_total++;
            if (ex_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, ex_valid);
            else n_pass++;
            n_total++;
            if (dut_bundle() !== e) $display("FAIL stream_bundle[%0d]: got %h want %h", i, dut_bundle(), e);
            else n_pass++;
        end
        wb_we = 0;
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        bundle_t slot, nb;
        logic slot_v, ld, hz;
        ops[0] = OP_RTYPE; ops[1] = OP_J; ops[2] = OP_JAL;
        ops[3] = OP_BEQ; ops[4] = OP_LW; ops[5] = OP_SW;
        @(negedge clk);
        flush = 1; if_valid = 0; wb_we = 0;
        cycle();
        slot_v = 0; slot = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_instr = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 16'($urandom)};
            if_pc    = $urandom & 32'hFFFF_FFFC;
            wb_we    = 1'($urandom);
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            #1;
            ld = ex_ready || !slot_v;
            hz = slot_v && slot.mr && slot.rt != 5'd0 && if_valid &&
                 (slot.rt == if_instr[25:21] || slot.rt == if_instr[20:16]);
            n_total++;
            if (id_ready !== (ld && !hz)) $display("FAIL rand_ready[%0d]: got %b want %b", i, id_ready, ld && !hz);
            else n_pass++;
            nb = model_bundle(if_instr, if_pc);
            cycle();
            if (flush) slot_v = 0;
            else if (ld && hz) slot_v = 0;
            else if (ld) begin slot = nb; slot_v = if_valid; end
            n_total++;
            if (ex_valid !== slot_v) $display("FAIL rand_valid[%0d]: got %b want %b", i, ex_valid, slot_v);
            else n_pass++;
            if (slot_v) begin
                n_total++;
                if (dut_bundle() !== slot) $display("FAIL rand_bundle[%0d]: got %h want %h", i, dut_bundle(), slot);
                else n_pass++;
            end
        end
        flush = 0; wb_we = 0; if_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_bypass();
        test_addr();
        test_load_use();
        test_backpressure_flush();
        test_throughput();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
